// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_unit
// Brief    : Multi-cycle multiply/divide unit with HI/LO registers. Signed
//            MULT/DIV are compiled in with `define MULDIV_SIGNED_EN.
// Revision : 1.0
// ============================================================================
module mips_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam logic [2:0] c_OP_MTHI = 3'd4;
   localparam logic [2:0] c_OP_MTLO = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             is_div_q, is_div_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic             w_md_op;
   logic [WIDTH-1:0] w_x_mag, w_y_mag;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quo, w_rem;

`ifdef MULDIV_SIGNED_EN
   logic neg_pq_q, neg_pq_d;
   logic neg_r_q, neg_r_d;
   logic w_sgn_op, w_x_neg, w_y_neg, w_neg_pq;

   assign w_md_op  = ~op[2];
   assign w_sgn_op = ~op[2] & op[1];
   assign w_x_neg  = w_sgn_op & X[WIDTH-1];
   assign w_y_neg  = w_sgn_op & Y[WIDTH-1];
   assign w_x_mag  = w_x_neg ? -X : X;
   assign w_y_mag  = w_y_neg ? -Y : Y;
   // A zero divisor must still yield an all-ones quotient, so no sign flip.
   assign w_neg_pq = (w_x_neg ^ w_y_neg) & ~(op[0] & (Y == '0));
   assign w_prod   = neg_pq_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
   assign w_quo    = neg_pq_q ? -acc_lo_q : acc_lo_q;
   assign w_rem    = neg_r_q  ? -acc_hi_q : acc_hi_q;
`else
   assign w_md_op  = (op[2:1] == 2'b00);
   assign w_x_mag  = X;
   assign w_y_mag  = Y;
   assign w_prod   = {acc_hi_q, acc_lo_q};
   assign w_quo    = acc_lo_q;
   assign w_rem    = acc_hi_q;
`endif

   // Shift-add step: the multiplier drains out of acc_lo as the product enters.
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_mul_step;
   assign w_sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign w_mul_step = {w_sum, acc_lo_q[WIDTH-1:1]};

   // Restoring step: the partial remainder needs one extra bit before the trial subtract.
   logic [WIDTH:0]     w_div_up, w_div_trial;
   logic [2*WIDTH-1:0] w_div_step;
   assign w_div_up    = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign w_div_trial = w_div_up - {1'b0, opnd_q};
   assign w_div_step  = w_div_trial[WIDTH]
                      ? {w_div_up[WIDTH-1:0], acc_lo_q[WIDTH-2:0], 1'b0}
                      : {w_div_trial[WIDTH-1:0], acc_lo_q[WIDTH-2:0], 1'b1};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = dbz_q;
      done_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_pq_d = neg_pq_q;
      neg_r_d  = neg_r_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (w_md_op) begin
                  state_d  = S_RUN;
                  cnt_d    = CNT_W'(WIDTH);
                  is_div_d = op[0];
                  acc_hi_d = '0;
                  acc_lo_d = w_x_mag;
                  opnd_d   = w_y_mag;
`ifdef MULDIV_SIGNED_EN
                  neg_pq_d = w_neg_pq;
                  neg_r_d  = w_x_neg;
`endif
               end else if (op == c_OP_MTHI) begin
                  hi_d   = X;
                  done_d = 1'b1;
               end else if (op == c_OP_MTLO) begin
                  lo_d   = X;
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (is_div_q) {acc_hi_d, acc_lo_d} = w_div_step;
            else          {acc_hi_d, acc_lo_d} = w_mul_step;
            if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
         end
         S_FINISH: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
               lo_d  = w_quo;
               hi_d  = w_rem;
               dbz_d = (opnd_q == '0);
            end else begin
               {hi_d, lo_d} = w_prod;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_pq_q <= 1'b0;
         neg_r_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_EN
         neg_pq_q <= neg_pq_d;
         neg_r_q  <= neg_r_d;
`endif
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign HI          = hi_q;
   assign LO          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_muldiv_unit
// Brief    : Self-checking bench for mips_muldiv_unit against an arithmetic
//            reference model; honours `define MULDIV_SIGNED_EN.
// Revision : 1.0
// ============================================================================
module tb_mips_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd7;
   logic [W-1:0] X = '0;
   logic [W-1:0] Y = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] HI, LO;

   int tests_run = 0;
   int tests_failed = 0;

   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic         m_dbz = 1'b0;

   int   edges, busy_cnt;
   logic done_busy;

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .X(X), .Y(Y),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Architectural reference: what HI/LO/div_by_zero become once op completes.
   task automatic model_apply(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         3'd0: {m_hi, m_lo} = {32'b0, x} * {32'b0, y};
         3'd1: begin
            if (y == 0) begin m_hi = x; m_lo = '1; m_dbz = 1'b1; end
            else begin m_lo = x / y; m_hi = x % y; m_dbz = 1'b0; end
         end
`ifdef MULDIV_SIGNED_EN
         3'd2: {m_hi, m_lo} = 64'(sx * sy);
         3'd3: begin
            if (y == 0) begin m_hi = x; m_lo = '1; m_dbz = 1'b1; end
            else begin
               q = sx / sy; r = sx % sy;
               m_lo = 32'(q); m_hi = 32'(r); m_dbz = 1'b0;
            end
         end
`endif
         3'd4: m_hi = x;
         3'd5: m_lo = x;
         default: ;
      endcase
   endtask

   // Counts edges after the accepting edge until done is seen (bounded).
   task automatic wait_done();
      edges = 0; busy_cnt = 0;
      while (done !== 1'b1 && edges < 100) begin
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
         edges++;
      end
      done_busy = busy;
   endtask

   task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1; op = o; X = x; Y = y;
      model_apply(o, x, y);
      @(negedge clk);
      start = 1'b0; X = $urandom; Y = $urandom;
      wait_done();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
      tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
      tests_run++; if (HI !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", HI); end
      tests_run++; if (LO !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", LO); end
   endtask

   task automatic test_multu();
      do_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tests_run++; if (edges !== 33) begin tests_failed++; $display("FAIL multu_latency: got %0d expected 33", edges); end
      tests_run++; if (busy_cnt !== 33) begin tests_failed++; $display("FAIL multu_busy_cycles: got %0d expected 33", busy_cnt); end
      tests_run++; if (done_busy !== 1'b0) begin tests_failed++; $display("FAIL multu_busy_at_done: got %b expected 0", done_busy); end
      tests_run++; if (HI !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL multu_hi: got %h expected fffffffe", HI); end
      tests_run++; if (LO !== 32'h00000001) begin tests_failed++; $display("FAIL multu_lo: got %h expected 00000001", LO); end
      @(negedge clk);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_divu();
      do_op(3'd1, 32'd100, 32'd7);
      tests_run++; if (LO !== 32'd14) begin tests_failed++; $display("FAIL divu_quo: got %0d expected 14", LO); end
      tests_run++; if (HI !== 32'd2) begin tests_failed++; $display("FAIL divu_rem: got %0d expected 2", HI); end
      tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL divu_dbz: got %b expected 0", div_by_zero); end
      do_op(3'd1, 32'd5, 32'd0);
      tests_run++; if (edges !== 33) begin tests_failed++; $display("FAIL divz_latency: got %0d expected 33", edges); end
      tests_run++; if (HI !== 32'd5) begin tests_failed++; $display("FAIL divz_hi: got %h expected 5", HI); end
      tests_run++; if (LO !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL divz_lo: got %h expected ffffffff", LO); end
      tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL divz_dbz: got %b expected 1", div_by_zero); end
      do_op(3'd0, 32'd3, 32'd4);
      tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL mul_keeps_dbz: got %b expected 1", div_by_zero); end
      tests_run++; if (LO !== 32'd12) begin tests_failed++; $display("FAIL mul_small_lo: got %0d expected 12", LO); end
      tests_run++; if (HI !== 32'd0) begin tests_failed++; $display("FAIL mul_small_hi: got %0d expected 0", HI); end
   endtask

   task automatic test_ignored(input logic [2:0] o);
      logic [W-1:0] hi0, lo0;
      logic saw_busy, saw_done;
      hi0 = HI; lo0 = LO; saw_busy = 1'b0; saw_done = 1'b0;
      @(negedge clk);
      start = 1'b1; op = o; X = $urandom; Y = $urandom;
      @(negedge clk);
      start = 1'b0;
      repeat (40) begin
         if (busy === 1'b1) saw_busy = 1'b1;
         if (done === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      tests_run++; if (saw_busy !== 1'b0) begin tests_failed++; $display("FAIL ignored_op%0d_busy: got 1 expected 0", o); end
      tests_run++; if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL ignored_op%0d_done: got 1 expected 0", o); end
      tests_run++; if (HI !== hi0 || LO !== lo0) begin tests_failed++; $display("FAIL ignored_op%0d_hilo: got %h/%h expected %h/%h", o, HI, LO, hi0, lo0); end
   endtask

`ifdef MULDIV_SIGNED_EN
   task automatic test_signed();
      do_op(3'd3, 32'hFFFFFFF9, 32'd2);
      tests_run++; if (LO !== 32'hFFFFFFFD) begin tests_failed++; $display("FAIL div_neg_quo: got %h expected fffffffd", LO); end
      tests_run++; if (HI !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL div_neg_rem: got %h expected ffffffff", HI); end
      do_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
      tests_run++; if (LO !== 32'h80000000) begin tests_failed++; $display("FAIL div_ovf_quo: got %h expected 80000000", LO); end
      tests_run++; if (HI !== 32'h0) begin tests_failed++; $display("FAIL div_ovf_rem: got %h expected 0", HI); end
      do_op(3'd2, 32'hFFFFFFFD, 32'd5);
      tests_run++; if (HI !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mult_neg_hi: got %h expected ffffffff", HI); end
      tests_run++; if (LO !== 32'hFFFFFFF1) begin tests_failed++; $display("FAIL mult_neg_lo: got %h expected fffffff1", LO); end
      tests_run++; if (edges !== 33) begin tests_failed++; $display("FAIL mult_latency: got %0d expected 33", edges); end
   endtask
`else
   task automatic test_signed();
      test_ignored(3'd2);
      test_ignored(3'd3);
   endtask
`endif

   task automatic test_mthi_mtlo();
      do_op(3'd4, 32'hDEADBEEF, $urandom);
      tests_run++; if (HI !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL mthi_hi: got %h expected deadbeef", HI); end
      tests_run++; if (edges !== 0) begin tests_failed++; $display("FAIL mthi_latency: got %0d expected 0", edges); end
      tests_run++; if (busy_cnt !== 0) begin tests_failed++; $display("FAIL mthi_busy: got %0d expected 0", busy_cnt); end
      tests_run++; if (LO !== m_lo) begin tests_failed++; $display("FAIL mthi_lo_kept: got %h expected %h", LO, m_lo); end
      do_op(3'd5, 32'h12345678, $urandom);
      tests_run++; if (LO !== 32'h12345678) begin tests_failed++; $display("FAIL mtlo_lo: got %h expected 12345678", LO); end
      tests_run++; if (HI !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL mtlo_hi_kept: got %h expected deadbeef", HI); end
      tests_run++; if (div_by_zero !== m_dbz) begin tests_failed++; $display("FAIL mtlo_dbz_kept: got %b expected %b", div_by_zero, m_dbz); end
   endtask

   task automatic test_busy_ignore();
      logic saw_done;
      @(negedge clk);
      start = 1'b1; op = 3'd0; X = 32'd1000; Y = 32'd3000;
      model_apply(3'd0, 32'd1000, 32'd3000);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; op = 3'd1; X = 32'd77; Y = 32'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      tests_run++; if (edges >= 100) begin tests_failed++; $display("FAIL busy_ignore_timeout: got no done expected done"); end
      tests_run++; if (HI !== m_hi || LO !== m_lo) begin tests_failed++; $display("FAIL busy_ignore_result: got %h/%h expected %h/%h", HI, LO, m_hi, m_lo); end
      saw_done = 1'b0;
      @(negedge clk);
      repeat (40) begin
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      tests_run++; if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL busy_ignore_queued: got activity expected none"); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a_hi, a_lo;
      @(negedge clk);
      start = 1'b1; op = 3'd0; X = 32'hCAFE1234; Y = 32'h00FF00FF;
      model_apply(3'd0, 32'hCAFE1234, 32'h00FF00FF);
      a_hi = m_hi; a_lo = m_lo;
      @(negedge clk);
      op = 3'd1; X = 32'd1000003; Y = 32'd97;
      wait_done();
      model_apply(3'd1, 32'd1000003, 32'd97);
      tests_run++; if (HI !== a_hi || LO !== a_lo) begin tests_failed++; $display("FAIL b2b_first: got %h/%h expected %h/%h", HI, LO, a_hi, a_lo); end
      tests_run++; if (done_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_at_done: got %b expected 0", done_busy); end
      @(negedge clk);
      start = 1'b0; X = $urandom; Y = $urandom;
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
      wait_done();
      tests_run++; if (edges !== 33) begin tests_failed++; $display("FAIL b2b_latency: got %0d expected 33", edges); end
      tests_run++; if (HI !== m_hi || LO !== m_lo) begin tests_failed++; $display("FAIL b2b_second: got %h/%h expected %h/%h", HI, LO, m_hi, m_lo); end
   endtask

   task automatic test_random();
      logic [2:0] pool[$];
      logic [2:0] o;
      logic [W-1:0] x, y;
      pool = '{3'd0, 3'd1, 3'd4, 3'd5};
`ifdef MULDIV_SIGNED_EN
      pool.push_back(3'd2);
      pool.push_back(3'd3);
`endif
      for (int i = 0; i < 24; i++) begin
         o = pool[$urandom_range(0, pool.size() - 1)];
         x = $urandom;
         y = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 255)) : 32'($urandom));
         if ($urandom_range(0, 5) == 0) x = 32'h80000000;
         do_op(o, x, y);
         tests_run++; if (HI !== m_hi) begin tests_failed++; $display("FAIL rand%0d_op%0d_hi: x=%h y=%h got %h expected %h", i, o, x, y, HI, m_hi); end
         tests_run++; if (LO !== m_lo) begin tests_failed++; $display("FAIL rand%0d_op%0d_lo: x=%h y=%h got %h expected %h", i, o, x, y, LO, m_lo); end
         tests_run++; if (div_by_zero !== m_dbz) begin tests_failed++; $display("FAIL rand%0d_op%0d_dbz: got %b expected %b", i, o, div_by_zero, m_dbz); end
         tests_run++; if (edges !== ((o <= 3'd3) ? 33 : 0)) begin tests_failed++; $display("FAIL rand%0d_op%0d_latency: got %0d expected %0d", i, o, edges, (o <= 3'd3) ? 33 : 0); end
      end
   endtask

   task automatic test_reset_mid_run();
      logic saw_done;
      do_op(3'd1, 32'd9, 32'd0);
      @(negedge clk);
      start = 1'b1; op = 3'd0; X = 32'd7; Y = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_running: got busy %b expected 1", busy); end
      #2 rst = 1'b1;
      #1;
      tests_run++; if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin tests_failed++; $display("FAIL rstmid_async: got busy %b hi %h lo %h expected 0/0/0", busy, HI, LO); end
      @(negedge clk);
      tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ctrl: got busy %b done %b expected 0/0", busy, done); end
      tests_run++; if (HI !== 32'h0 || LO !== 32'h0 || div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL rstmid_regs: got %h/%h/%b expected 0/0/0", HI, LO, div_by_zero); end
      rst = 1'b0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      saw_done = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      tests_run++; if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_done: got activity expected none"); end
      tests_run++; if (HI !== 32'h0 || LO !== 32'h0) begin tests_failed++; $display("FAIL rstmid_hilo_after: got %h/%h expected 0/0", HI, LO); end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_divu();
      test_signed();
      test_ignored(3'd6);
      test_ignored(3'd7);
      test_mthi_mtlo();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS CPU datapath. It provides the MULTU/DIVU operations that the combinational ALU returns as zero. The operand width is parametrised, and the unit uses a start/busy/done handshake. The datapath stalls on busy and reads HI/LO directly (MFHI/MFLO).

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be ≥ 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
op  input  3  0=MULTU, 1=DIVU, 2=MULT, 3=DIV, 4=MTHI, 5=MTLO, 6/7=no-op.
X  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
Y  input  WIDTH  rt operand (multiplier / divisor).
busy  output  1  iteration in progress; new start is ignored.
done  output  1  single-cycle pulse; HI/LO are updated and valid in this cycle.
div_by_zero  output  1  sticky flag from the last completed divide: 1 if Y was 0.
HI  output  WIDTH  product high half / remainder.
LO  output  WIDTH  product low half / quotient.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, div_by_zero=0, HI=0, LO=0; internal accumulators and counter cleared. Reset mid-operation aborts it with no partial write.
- FSM states: IDLE, RUN, FINISH.
- IDLE, start=1, op in {0..3} (op 2/3 only when the optional feature is compiled in):
  - latch operands into a 2*WIDTH working register; counter=WIDTH; go to RUN.
  - busy=1 from the next cycle.
- IDLE, start=1, op=4/5: write HI (op 4) or LO (op 5) from X at that edge. done=1 in the following cycle; busy stays 0; state stays IDLE.
- IDLE, start=1, op=6/7 or an unsupported op: ignored; no done.
- RUN: one iteration per cycle, counter decrements; after WIDTH iterations go to FINISH.
  - Multiply: shift-add, 1 multiplier bit per cycle.
  - Divide: restoring, 1 quotient bit per cycle.
- FINISH edge: write HI/LO; done=1 and busy=0 for exactly one cycle; return to IDLE.
- Latency: start sampled at edge N → done high and HI/LO valid in the cycle after edge N+WIDTH+1. busy is high for WIDTH+1 cycles.
- A start held high during the done cycle is accepted (busy=0 there), so back-to-back operations are possible.
- start while busy=1 is ignored and not queued. Operands are captured at acceptance; X/Y changes afterwards have no effect.
- Multiply: {HI,LO} = full 2*WIDTH-bit product, with no truncation.
- Divide: LO = quotient, HI = remainder, truncation toward zero.
  - Y=0: full latency still taken; HI=X, LO=all ones; div_by_zero=1.
  - Any divide with Y≠0 clears div_by_zero. Multiply and MTHI/MTLO leave it unchanged.
- Signed ops (when enabled):
  - Operate on magnitudes, then fix signs: quotient sign = sign(X) xor sign(Y); remainder sign = sign(X); product sign = xor.
  - Overflow case X = most-negative, Y = −1 gives LO = most-negative, HI = 0.
- HI/LO hold their values between operations and never change outside FINISH or MTHI/MTLO.

Optional Feature:
MULDIV_SIGNED_EN
- Defined: op 2 (MULT) and op 3 (DIV) are supported with two's-complement semantics as above; adds the sign-fix logic.
- Undefined: op 2/3 are treated exactly like op 6/7 (ignored, no busy, no done). No signed logic is synthesised.

Test Plan:
1. Reset mid-RUN of MULTU 7×9 → busy=0, done=0, HI=0, LO=0 on the next edge after rst; no done ever pulses.
2. MULTU X=0xFFFFFFFF, Y=0xFFFFFFFF (WIDTH=32) → done exactly 33 edges after the start edge; HI=0xFFFFFFFE, LO=0x00000001; busy high for 33 cycles.
3. DIVU X=100, Y=7 → LO=14, HI=2, div_by_zero=0. Then DIVU X=5, Y=0 → HI=5, LO=0xFFFFFFFF, div_by_zero=1. Then MULTU 3×4 → div_by_zero still 1, LO=12.
4. With MULDIV_SIGNED_EN: DIV X=−7, Y=2 → LO=−3, HI=−1. DIV X=0x80000000, Y=−1 → LO=0x80000000, HI=0. MULT −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
5. Without MULDIV_SIGNED_EN: start with op=2 → busy and done stay 0 and HI/LO are unchanged.
6. Handshake:
   - start pulsed while busy → ignored; results match the first op only.
   - start held high through done → second op accepted in the done cycle.
   - MTHI X=0xDEADBEEF → HI=0xDEADBEEF, done one cycle later, busy never asserts.
